// File: rtl/rdmap_pkg.sv
// Shared types and constants for the range-Doppler corner-turn buffer.
// Bank, write-FSM and read-FSM state encodings plus shadow-register reset values.
package rdmap_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        WRITING = 2'd1,
        FULL    = 2'd2,
        READING = 2'd3
    } bank_state_t;

    typedef enum logic [1:0] {
        WR_IDLE  = 2'd0,
        WR_WRITE = 2'd1,
        WR_DROP  = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_READ  = 2'd1,
        RD_DRAIN = 2'd2
    } rd_state_t;

    // Frame geometry as captured from the shadow registers.
    typedef struct packed {
        logic [15:0] samples;
        logic [15:0] chirps;
        logic [15:0] rstart;
        logic [15:0] rstop;
    } dims_t;

    localparam logic [15:0] DEF_SAMPLE_NUM  = 16'd256;
    localparam logic [15:0] DEF_CHIRP_NUM   = 16'd32;
    localparam logic [15:0] DEF_RANGE_START = 16'd0;
    localparam logic [15:0] DEF_RANGE_STOP  = 16'd255;

    function automatic logic [15:0] min16(input logic [15:0] a, input logic [15:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/rdmap_corner_turn_ram.sv
// Simple dual-port bank RAM with a registered read port (1-cycle latency).
module ct_bank_ram #(
    parameter int DATA_W = 32,
    parameter int AW     = 15
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/rdmap_corner_turn.sv
// Ping-pong corner-turn: chirp rows in, range-bin columns out, with per-bank
// geometry capture, output backpressure, range-bin gating and frame-drop reporting.
module rdmap_corner_turn
    import rdmap_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int SAMPLE_AW  = 10,
    parameter int CHIRP_AW   = 5,
    parameter int DROP_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [15:0]           sample_num,
    input  logic [15:0]           chirp_num,
    input  logic [15:0]           range_start,
    input  logic [15:0]           range_stop,
    input  logic                  config_trigger,
    input  logic                  s_valid,
    input  logic [DATA_W-1:0]     s_data,
    input  logic                  s_sop,
    input  logic                  s_eop,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_W-1:0]     m_data,
    output logic                  m_sop,
    output logic                  m_eop,
    output logic                  m_last,
    output logic                  overflow,
    output logic                  len_err,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam int AW = SAMPLE_AW + CHIRP_AW;

    dims_t       shadow;
    dims_t       bank_dims [2];
    bank_state_t bank_st   [2];
    logic        last_full;

    // ---------------- write side ----------------
    wr_state_t   wr_state;
    logic        wr_bank;
    logic [15:0] wr_sample, wr_chirp, wr_samples, wr_chirps;

    logic        free0, free1, frame_start, start_write, start_drop, new_bank;
    logic        beat_in, writing, row_restart, chirp_end, frame_end, wr_done, len_bad;
    logic        tgt_bank, ram_wr;
    logic [15:0] eff_samples, eff_chirps, cur_sample, cur_chirp;
    logic [AW-1:0] wr_addr;

    always_comb begin
        free0       = (bank_st[0] == EMPTY);
        free1       = (bank_st[1] == EMPTY);
        frame_start = (wr_state == WR_IDLE) && s_valid && s_sop;
        start_write = frame_start && (free0 || free1);
        start_drop  = frame_start && !(free0 || free1);
        new_bank    = !free0;
        beat_in     = s_valid && ((wr_state != WR_IDLE) || frame_start);
        writing     = s_valid && (start_write || (wr_state == WR_WRITE));
        row_restart = (wr_state == WR_WRITE) && s_valid && s_sop && (wr_sample != 16'd0);
        eff_samples = frame_start ? shadow.samples : wr_samples;
        eff_chirps  = frame_start ? shadow.chirps  : wr_chirps;
        cur_sample  = (frame_start || s_sop) ? 16'd0 : wr_sample;
        cur_chirp   = frame_start ? 16'd0 : wr_chirp;
        tgt_bank    = frame_start ? new_bank : wr_bank;
        // Beats past the configured row length are discarded, not wrapped.
        ram_wr      = writing && (cur_sample < eff_samples);
        wr_addr     = {cur_chirp[CHIRP_AW-1:0], cur_sample[SAMPLE_AW-1:0]};
        chirp_end   = beat_in && s_eop;
        frame_end   = chirp_end && (cur_chirp == eff_chirps - 16'd1);
        wr_done     = frame_end && writing;
        len_bad     = writing && s_eop && (cur_sample + 16'd1 != eff_samples);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '{samples: DEF_SAMPLE_NUM, chirps: DEF_CHIRP_NUM,
                        rstart: DEF_RANGE_START, rstop: DEF_RANGE_STOP};
        end else if (config_trigger) begin
            shadow <= '{samples: sample_num, chirps: chirp_num,
                        rstart: range_start, rstop: range_stop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state   <= WR_IDLE;
            wr_bank    <= 1'b0;
            wr_sample  <= 16'd0;
            wr_chirp   <= 16'd0;
            wr_samples <= 16'd0;
            wr_chirps  <= 16'd0;
            overflow   <= 1'b0;
            len_err    <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            if (start_drop) begin
                overflow <= 1'b1;
                if (drop_cnt != '1) begin
                    drop_cnt <= drop_cnt + 1'b1;
                end
            end
            if (len_bad || row_restart) begin
                len_err <= 1'b1;
            end
            if (beat_in) begin
                if (frame_start) begin
                    wr_bank    <= new_bank;
                    wr_samples <= shadow.samples;
                    wr_chirps  <= shadow.chirps;
                end
                if (frame_end) begin
                    wr_state  <= WR_IDLE;
                    wr_sample <= 16'd0;
                    wr_chirp  <= 16'd0;
                end else begin
                    if (frame_start) begin
                        wr_state <= start_write ? WR_WRITE : WR_DROP;
                    end
                    if (chirp_end) begin
                        wr_chirp  <= cur_chirp + 16'd1;
                        wr_sample <= 16'd0;
                    end else begin
                        wr_chirp  <= cur_chirp;
                        wr_sample <= cur_sample + 16'd1;
                    end
                end
            end
        end
    end

    // ---------------- read side ----------------
    rd_state_t   rd_state;
    logic        rd_bank;
    logic [15:0] rd_bin, rd_chirp, rd_stop, rd_chirps;

    logic        full0, full1, sel, take, empty_range, take_ok, issue, release_bank, rel_bank;
    logic        iss_bank, col_end, iss_last, space, pop;
    logic [15:0] lo, hi, cur_bin, cur_rchirp, cur_chirps, cur_stop;
    logic [2:0]  in_use;
    dims_t       sel_dims;
    logic [AW-1:0] rd_addr;

    logic        pend, pend_sop, pend_eop, pend_last, pend_bank;
    logic [DATA_W+2:0] fifo_mem [2];
    logic        fifo_wp, fifo_rp;
    logic [1:0]  fifo_cnt;

    logic [1:0]        ram_we, ram_re;
    logic [DATA_W-1:0] ram_rdata [2];

    // Output handshake: a beat transfers on a rising edge where m_valid && m_ready;
    // m_valid never drops and m_data/flags never change until that transfer.
    assign m_valid = (fifo_cnt != 2'd0);
    assign pop     = m_valid && m_ready;
    assign {m_data, m_sop, m_eop, m_last} = fifo_mem[fifo_rp];

    always_comb begin
        full0       = (bank_st[0] == FULL);
        full1       = (bank_st[1] == FULL);
        // Both FULL: the one not most recently filled is the older frame.
        sel         = (full0 && full1) ? ~last_full : full1;
        take        = (rd_state == RD_IDLE) && (full0 || full1);
        sel_dims    = bank_dims[sel];
        lo          = min16(sel_dims.rstart, sel_dims.samples - 16'd1);
        hi          = min16(sel_dims.rstop,  sel_dims.samples - 16'd1);
        empty_range = (lo > hi);
        take_ok     = take && !empty_range;
        // Credit: FIFO entries plus the in-flight RAM read must fit in two slots.
        in_use      = {1'b0, fifo_cnt} + {2'b00, pend};
        space       = in_use < (3'd2 + {2'b00, pop});
        issue       = take_ok || ((rd_state == RD_READ) && space);
        cur_bin     = take ? lo : rd_bin;
        cur_rchirp  = take ? 16'd0 : rd_chirp;
        cur_chirps  = take ? sel_dims.chirps : rd_chirps;
        cur_stop    = take ? hi : rd_stop;
        iss_bank    = take ? sel : rd_bank;
        col_end     = (cur_rchirp == cur_chirps - 16'd1);
        iss_last    = col_end && (cur_bin == cur_stop);
        rd_addr     = {cur_rchirp[CHIRP_AW-1:0], cur_bin[SAMPLE_AW-1:0]};
        release_bank = (take && empty_range) ||
                       ((rd_state == RD_DRAIN) && (fifo_cnt == 2'd0) && !pend);
        rel_bank    = take ? sel : rd_bank;
        ram_we = 2'b00;
        ram_re = 2'b00;
        if (ram_wr) ram_we[tgt_bank] = 1'b1;
        if (issue)  ram_re[iss_bank] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state  <= RD_IDLE;
            rd_bank   <= 1'b0;
            rd_bin    <= 16'd0;
            rd_chirp  <= 16'd0;
            rd_stop   <= 16'd0;
            rd_chirps <= 16'd0;
        end else begin
            if (take) begin
                rd_bank   <= sel;
                rd_stop   <= hi;
                rd_chirps <= sel_dims.chirps;
            end
            if (issue) begin
                if (iss_last) begin
                    rd_state <= RD_DRAIN;
                end else begin
                    rd_state <= RD_READ;
                    if (col_end) begin
                        rd_chirp <= 16'd0;
                        rd_bin   <= cur_bin + 16'd1;
                    end else begin
                        rd_chirp <= cur_rchirp + 16'd1;
                        rd_bin   <= cur_bin;
                    end
                end
            end else if ((rd_state == RD_DRAIN) && release_bank) begin
                rd_state <= RD_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_st[0]   <= EMPTY;
            bank_st[1]   <= EMPTY;
            bank_dims[0] <= '0;
            bank_dims[1] <= '0;
            last_full    <= 1'b1;
        end else begin
            if (start_write) begin
                bank_st[new_bank]   <= WRITING;
                bank_dims[new_bank] <= shadow;
            end
            if (wr_done) begin
                bank_st[tgt_bank] <= FULL;
                last_full         <= tgt_bank;
            end
            if (take_ok) begin
                bank_st[sel] <= READING;
            end
            if (release_bank) begin
                bank_st[rel_bank] <= EMPTY;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend        <= 1'b0;
            pend_sop    <= 1'b0;
            pend_eop    <= 1'b0;
            pend_last   <= 1'b0;
            pend_bank   <= 1'b0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            fifo_wp     <= 1'b0;
            fifo_rp     <= 1'b0;
            fifo_cnt    <= 2'd0;
        end else begin
            pend      <= issue;
            pend_sop  <= (cur_rchirp == 16'd0);
            pend_eop  <= col_end;
            pend_last <= iss_last;
            pend_bank <= iss_bank;
            if (pend) begin
                fifo_mem[fifo_wp] <= {ram_rdata[pend_bank], pend_sop, pend_eop, pend_last};
                fifo_wp <= ~fifo_wp;
            end
            if (pop) begin
                fifo_rp <= ~fifo_rp;
            end
            fifo_cnt <= fifo_cnt + 2'(pend) - 2'(pop);
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        ct_bank_ram #(
            .DATA_W(DATA_W),
            .AW    (AW)
        ) u_ram (
            .clk  (clk),
            .we   (ram_we[b]),
            .waddr(wr_addr),
            .wdata(s_data),
            .re   (ram_re[b]),
            .raddr(rd_addr),
            .rdata(ram_rdata[b])
        );
    end

endmodule

// File: tb/tb_rdmap_corner_turn.sv
// Directed bench for rdmap_corner_turn: table of frame geometries plus
// hand-written backpressure/overflow, length-error, reconfig and reset sequences.
module tb_rdmap_corner_turn;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] sample_num, chirp_num, range_start, range_stop;
    logic        config_trigger;
    logic        s_valid, s_sop, s_eop;
    logic [31:0] s_data;
    logic        m_valid, m_ready, m_sop, m_eop, m_last;
    logic [31:0] m_data;
    logic        overflow, len_err;
    logic [7:0]  drop_cnt;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_beats  = 0;
    bit          rnd_mode = 1'b0;
    bit          ready_lvl = 1'b1;

    // {dc, sop, eop, last, data}
    logic [35:0] exp_q[$];

    typedef struct {
        int sn;
        int cn;
        int rs;
        int re;
        int exp_beats;
        bit rnd;
    } vec_t;
    vec_t vecs[6];

    rdmap_corner_turn dut (
        .clk(clk), .rst_n(rst_n),
        .sample_num(sample_num), .chirp_num(chirp_num),
        .range_start(range_start), .range_stop(range_stop),
        .config_trigger(config_trigger),
        .s_valid(s_valid), .s_data(s_data), .s_sop(s_sop), .s_eop(s_eop),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_sop(m_sop), .m_eop(m_eop), .m_last(m_last),
        .overflow(overflow), .len_err(len_err), .drop_cnt(drop_cnt)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    initial begin : ready_drv
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            m_ready = rnd_mode ? 1'($urandom_range(0, 1)) : ready_lvl;
        end
    end

    task automatic cfg(input int sn, input int cn, input int rs, input int re);
        sample_num     = 16'(sn);
        chirp_num      = 16'(cn);
        range_start    = 16'(rs);
        range_stop     = 16'(re);
        config_trigger = 1'b1;
        tick();
        config_trigger = 1'b0;
    endtask

    task automatic send_chirp(input int tag, input int c, input int nb);
        for (int b = 0; b < nb; b++) begin
            s_valid = 1'b1;
            s_sop   = (b == 0);
            s_eop   = (b == nb - 1);
            s_data  = 32'(tag * 4096 + c * 16 + b);
            tick();
        end
        s_valid = 1'b0;
        s_sop   = 1'b0;
        s_eop   = 1'b0;
    endtask

    task automatic send_frame(input int tag, input int sn, input int cn);
        for (int c = 0; c < cn; c++) begin
            send_chirp(tag, c, sn);
        end
    endtask

    // Column-order expectation for one frame; entries of chirp dc_c at bins >= dc_b
    // carry don't-care data.
    task automatic expect_frame(input int tag, input int sn, input int cn, input int rs,
                                input int re, input int dc_c, input int dc_b);
        int lo;
        int hi;
        logic [35:0] e;
        lo = (rs < sn - 1) ? rs : sn - 1;
        hi = (re < sn - 1) ? re : sn - 1;
        for (int b = lo; b <= hi; b++) begin
            for (int c = 0; c < cn; c++) begin
                e[31:0] = 32'(tag * 4096 + c * 16 + b);
                e[34]   = (c == 0);
                e[33]   = (c == cn - 1);
                e[32]   = (c == cn - 1) && (b == hi);
                e[35]   = (c == dc_c) && (b >= dc_b);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while ((exp_q.size() != 0) && (k < 4000)) begin
            tick();
            k++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
        repeat (8) tick();
    endtask

    // ---------------- scoreboard ----------------
    initial begin : monitor
        logic [35:0] e;
        logic [35:0] held;
        bit          hold;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    check("hold_stable", {28'd0, m_valid, m_sop, m_eop, m_last, m_data},
                          {28'd0, 1'b1, held[34:0]});
                end
                hold = m_valid && !m_ready;
                held = {1'b0, m_sop, m_eop, m_last, m_data};
                if (m_valid && m_ready) begin
                    n_beats++;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL extra_beat: got data %0h, no beat expected", m_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (e[35]) begin
                            check("beat_flags", {61'd0, m_sop, m_eop, m_last}, {61'd0, e[34:32]});
                        end else begin
                            check("beat", {29'd0, m_sop, m_eop, m_last, m_data}, {29'd0, e[34:0]});
                        end
                    end
                end
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        vecs[0] = '{sn: 8,  cn: 4, rs: 0,  re: 255, exp_beats: 32,  rnd: 1'b0};
        vecs[1] = '{sn: 8,  cn: 4, rs: 2,  re: 5,   exp_beats: 16,  rnd: 1'b0};
        vecs[2] = '{sn: 8,  cn: 4, rs: 6,  re: 3,   exp_beats: 0,   rnd: 1'b0};
        vecs[3] = '{sn: 16, cn: 8, rs: 0,  re: 255, exp_beats: 128, rnd: 1'b1};
        vecs[4] = '{sn: 4,  cn: 2, rs: 1,  re: 9,   exp_beats: 6,   rnd: 1'b0};
        vecs[5] = '{sn: 8,  cn: 4, rs: 10, re: 12,  exp_beats: 4,   rnd: 1'b0};

        rst_n = 1'b0;
        sample_num = '0; chirp_num = '0; range_start = '0; range_stop = '0;
        config_trigger = 1'b0;
        s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0; s_data = '0;
        repeat (3) tick();
        check("rst_m_valid",  64'(m_valid),  64'd0);
        check("rst_m_data",   64'(m_data),   64'd0);
        check("rst_m_flags",  64'({m_sop, m_eop, m_last}), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_len_err",  64'(len_err),  64'd0);
        check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            rnd_mode  = vecs[i].rnd;
            ready_lvl = 1'b1;
            cfg(vecs[i].sn, vecs[i].cn, vecs[i].rs, vecs[i].re);
            expect_frame(i, vecs[i].sn, vecs[i].cn, vecs[i].rs, vecs[i].re, -1, 0);
            n_beats = 0;
            tick();
            send_frame(i, vecs[i].sn, vecs[i].cn);
            if (i == 0) begin
                tick();
                check("latency_c1", 64'(m_valid), 64'd0);
                tick();
                check("latency_c2", 64'(m_valid), 64'd1);
            end
            wait_drain("vec_drain");
            check("vec_beats", 64'(n_beats), 64'(vecs[i].exp_beats));
        end
        rnd_mode = 1'b0;
        check("tbl_overflow", 64'(overflow), 64'd0);
        check("tbl_drop_cnt", 64'(drop_cnt), 64'd0);
        check("tbl_len_err",  64'(len_err),  64'd0);

        // Reconfigure mid-frame: frame 10 keeps 8x4, frame 11 uses 16x4.
        cfg(8, 4, 0, 255);
        expect_frame(10, 8, 4, 0, 255, -1, 0);
        expect_frame(11, 16, 4, 0, 255, -1, 0);
        n_beats = 0;
        send_chirp(10, 0, 8);
        send_chirp(10, 1, 8);
        cfg(16, 4, 0, 255);
        send_chirp(10, 2, 8);
        send_chirp(10, 3, 8);
        send_frame(11, 16, 4);
        wait_drain("recfg_drain");
        check("recfg_beats",   64'(n_beats), 64'd96);
        check("recfg_len_err", 64'(len_err), 64'd0);

        // Three back-to-back frames with the output stalled: third is dropped.
        ready_lvl = 1'b0;
        cfg(8, 4, 0, 255);
        expect_frame(20, 8, 4, 0, 255, -1, 0);
        expect_frame(21, 8, 4, 0, 255, -1, 0);
        n_beats = 0;
        send_frame(20, 8, 4);
        send_frame(21, 8, 4);
        send_frame(22, 8, 4);
        repeat (4) tick();
        check("ovf_overflow", 64'(overflow), 64'd1);
        check("ovf_drop_cnt", 64'(drop_cnt), 64'd1);
        check("ovf_stalled_valid", 64'(m_valid), 64'd1);
        check("ovf_stalled_beats", 64'(n_beats), 64'd0);
        ready_lvl = 1'b1;
        wait_drain("ovf_drain");
        check("ovf_beats", 64'(n_beats), 64'd64);

        // Short chirp 1 (6 of 8 beats): length error, frame still delivered.
        cfg(8, 4, 0, 255);
        expect_frame(25, 8, 4, 0, 255, 1, 6);
        n_beats = 0;
        send_chirp(25, 0, 8);
        send_chirp(25, 1, 6);
        send_chirp(25, 2, 8);
        send_chirp(25, 3, 8);
        wait_drain("lenerr_drain");
        check("lenerr_flag",  64'(len_err), 64'd1);
        check("lenerr_beats", 64'(n_beats), 64'd32);

        // Asynchronous reset in the middle of a frame.
        cfg(8, 4, 0, 255);
        send_chirp(30, 0, 8);
        send_chirp(30, 1, 8);
        rst_n = 1'b0;
        #2;
        check("arst_overflow", 64'(overflow), 64'd0);
        check("arst_drop_cnt", 64'(drop_cnt), 64'd0);
        check("arst_len_err",  64'(len_err),  64'd0);
        check("arst_m_valid",  64'(m_valid),  64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        cfg(4, 2, 0, 255);
        expect_frame(31, 4, 2, 0, 255, -1, 0);
        n_beats = 0;
        send_frame(31, 4, 2);
        wait_drain("post_rst_drain");
        check("post_rst_beats", 64'(n_beats), 64'd8);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rdmap_corner_turn.md
Name: rdmap_corner_turn

Overview:
- Parametrised ping-pong corner-turn buffer for the range-Doppler chain.
- Accepts range-FFT output row-wise: one chirp per sop/eop packet, sample_num bins per chirp, chirp_num chirps per frame.
- Emits the same frame column-wise: per range bin, all chirps in order, to feed the Doppler window/FFT.
- Adds what the fixed-size row-to-column stage lacks: generic sizes, per-bank dimension capture, output backpressure, range-bin gating, frame-drop reporting.

Parameters:
- DATA_W, 32: sample width ({im,re}).
- SAMPLE_AW, 10: log2 of the maximum samples per chirp (1024).
- CHIRP_AW, 5: log2 of the maximum chirps per frame (32).
- DROP_CNT_W, 8: width of the dropped-frame counter.

Ports:
- clk  in  1  processing clock (160 MHz)
- rst_n  in  1  asynchronous active-low reset
- sample_num  in  16  samples per chirp; shadowed
- chirp_num  in  16  chirps per frame; shadowed
- range_start  in  16  first range bin output; shadowed
- range_stop  in  16  last range bin output (inclusive); shadowed
- config_trigger  in  1  1-cycle pulse; copies the four inputs above into the shadow registers
- s_valid  in  1  input beat valid; no backpressure
- s_data  in  DATA_W  input sample
- s_sop  in  1  first bin of a chirp
- s_eop  in  1  last bin of a chirp
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream accept
- m_data  out  DATA_W  output sample
- m_sop  out  1  first chirp of a range-bin column
- m_eop  out  1  last chirp of a column
- m_last  out  1  last beat of the frame
- overflow  out  1  sticky: a frame was dropped
- len_err  out  1  sticky: chirp length differed from sample_num
- drop_cnt  out  DROP_CNT_W  dropped frames; saturates at all-ones

Behaviour:
- Reset: all outputs 0, both banks EMPTY, write side IDLE, read side IDLE, shadows = {sample_num 256, chirp_num 32, range_start 0, range_stop 255}.
- Storage: 2 banks, each 2^(SAMPLE_AW+CHIRP_AW) x DATA_W, simple dual-port, 1-cycle read latency. Address = {chirp, sample}.
- Write FSM states:
  - IDLE: s_valid&s_sop starts a frame. If a bank is EMPTY, select it (bank0 preferred), latch the shadows into that bank's dimension registers, go WRITE. If no bank is EMPTY, go DROP, set overflow, increment drop_cnt.
  - WRITE: sample counter advances per beat. Beats at index >= sample_num are discarded. On s_eop, if count+1 != sample_num, set len_err; the chirp counter increments and the sample counter clears. After chirp chirp_num-1 eop, mark the bank FULL and go IDLE.
  - DROP: discard beats until eop of chirp chirp_num-1, then go IDLE.
  - An s_sop in WRITE with a nonzero sample counter sets len_err and restarts the current chirp row.
- Read FSM states:
  - IDLE: the oldest FULL bank (strict ping-pong order) is taken; go READ with bin = range_start (clamped to sample_num-1) and chirp = 0.
  - READ: chirp advances fastest, bin slowest, up to min(range_stop, sample_num-1). Pipeline: RAM read, then a 2-entry output skid buffer. The RAM read is issued only when the skid buffer has space, so no beat is lost or duplicated under any m_ready pattern.
  - After the final address is issued and the skid buffer drains, mark the bank EMPTY and go IDLE.
- Output timing: first m_valid is 2 cycles after the bank becomes FULL, provided the read side was IDLE and m_ready=1.
- Output flags:
  - m_sop on chirp 0, m_eop on chirp chirp_num-1 of each column.
  - m_last with m_eop of the final bin.
  - Flags travel with the data through the skid buffer.
- If range_start > range_stop after clamping: the bank is released with no output beats.
- One bank can be written while the other is read; same-cycle FULL and EMPTY transitions on different banks are both honoured.
- config_trigger mid-frame changes only the shadows; the active banks keep their latched dimensions.
- Asynchronous reset mid-frame clears all state immediately; partial data is abandoned.

Decomposition:
- Shared package rdmap_pkg holds:
  - bank-state enum {EMPTY, WRITING, FULL, READING};
  - write/read FSM enums;
  - reset-default constants for the shadow registers.
- One sub-module, ct_bank_ram: simple dual-port RAM, 1-cycle read latency. Instantiated twice.

Test Plan:
- sample_num=8, chirp_num=4, full range, m_ready=1, input data = chirp*16+bin → 32 beats in order 0,16,32,48,1,17,…; m_sop every 4th beat; m_last on beat 32.
- Three back-to-back 8x4 frames with m_ready=0 until the third frame starts → frames 1 and 2 buffered, frame 3 dropped, overflow=1, drop_cnt=1; after releasing m_ready, exactly 64 beats.
- m_ready toggled pseudo-randomly (50%) on a 16x8 frame → all 128 beats delivered once each, in order, with m_data stable while m_valid&!m_ready.
- range_start=2, range_stop=5, 8x4 frame → 16 beats, bins 2..5 only; range_start=6, range_stop=3 → no beats, bank freed.
- Chirp 1 eop after 6 beats with sample_num=8 → len_err=1, frame still output, bins 6..7 of chirp 1 unspecified.
- config_trigger with sample_num=16 during frame 1 (8x4) → frame 1 outputs 32 beats; frame 2 written and read as 16x4.
